conv_encoder_top: RTL and testbench

- Transmit-side counterpart of the Viterbi decoding chain. Accepts data bytes and encodes them with a rate-1/2 convolutional code (K=3, generators 7/5 octal).
- Emits one 16-bit codeword per byte, in the packing the decoder's 16-bit input expects.
- Contains an input byte FIFO, a serial encoder FSM with a persistent trellis state, an optional zero-tail flush, and a valid/ready output handshake.

---
 rtl/conv_encoder_top.sv | 168 ++++++++++++++++
 tb/tb_conv_encoder_top.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_top.sv
// Rate-1/2 convolutional encoder (K=3, generators 7/5 octal) with an input
// byte FIFO, a bit-serial encoder FSM whose trellis state persists across
// bytes, an optional zero-byte tail flush and a valid/ready output.
module conv_encoder_top #(
    parameter int             FIFO_DEPTH = 16,
    parameter int             K          = 3,
    parameter logic [K-1:0]   G0         = 3'b111,
    parameter logic [K-1:0]   G1         = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dvalid_i,
    input  logic [7:0]  data_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [15:0] data_o,
    output logic        valid_o,
    input  logic        ready_i
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {IDLE, WAIT, LOAD, ENC, OUT} state_t;

    // ------------------------------------------------------------------
    // Input byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    fifo_rdata;
    logic          full, empty, wr_en, rd_en, rd_fire;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A write while full is dropped even if a read frees a slot that cycle.
    assign wr_en   = dvalid_i && !full;
    assign rd_fire = rd_en && !empty;
    assign busy_o  = full;

    // Storage array: written on accepted writes only.
    // NOTE: the memory array has no reset; only pointers and the count decide
    // what is valid, so clearing the storage would add logic for nothing.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_i;
    end

    // Pointers, occupancy count and registered read data.
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_rdata <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) begin
                rd_ptr     <= rd_ptr + 1'b1;
                fifo_rdata <= mem[rd_ptr];
            end
            case ({wr_en, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Encoder FSM
    // ------------------------------------------------------------------
    state_t        state, state_d;
    logic [7:0]    sreg, sreg_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [15:0]   cw, cw_d, data_d;
    logic          valid_d, rd_en_d;
    logic [K-2:0]  trellis, trellis_d;
    logic          flush_pend, flush_clr;
    logic [K-1:0]  taps;
    logic          c0, c1;

    // Taps are {u, s1, s2}; u is the MSB still waiting in the shift register.
    assign taps = {sreg[7], trellis};
    assign c0   = ^(G0 & taps);
    assign c1   = ^(G1 & taps);

    // Next-state and next-register values for the encoder FSM.
    // NOTE: every signal gets a default before the case so no path leaves a
    // combinational output unassigned, which would infer a latch.
    always_comb begin
        state_d   = state;
        sreg_d    = sreg;
        bit_cnt_d = bit_cnt;
        cw_d      = cw;
        data_d    = data_o;
        valid_d   = valid_o;
        trellis_d = trellis;
        rd_en_d   = 1'b0;
        flush_clr = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    rd_en_d = 1'b1;
                    state_d = WAIT;
                end else if (flush_pend) begin
                    sreg_d    = 8'h00;
                    bit_cnt_d = '0;
                    flush_clr = 1'b1;
                    state_d   = ENC;
                end
            end
            WAIT: state_d = LOAD;
            LOAD: begin
                sreg_d    = fifo_rdata;
                bit_cnt_d = '0;
                state_d   = ENC;
            end
            ENC: begin
                cw_d      = {cw[13:0], c0, c1};
                trellis_d = taps[K-1:1];
                sreg_d    = {sreg[6:0], 1'b0};
                bit_cnt_d = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    data_d  = {cw[13:0], c0, c1};
                    valid_d = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers, plus the collapsing flush-request flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            cw         <= '0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            trellis    <= '0;
            rd_en      <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_d;
            sreg       <= sreg_d;
            bit_cnt    <= bit_cnt_d;
            cw         <= cw_d;
            data_o     <= data_d;
            valid_o    <= valid_d;
            trellis    <= trellis_d;
            rd_en      <= rd_en_d;
            // A pulse landing in the clearing cycle re-arms the flag.
            flush_pend <= (flush_pend && !flush_clr) || flush_i;
        end
    end

endmodule

// File: tb/tb_conv_encoder_top.sv
// Self-checking bench for conv_encoder_top: directed cases plus a randomized
// byte stream with random backpressure checked against a parity-arithmetic
// reference encoder.
module tb_conv_encoder_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dvalid_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] got[$];
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;

    int m_s1 = 0;
    int m_s2 = 0;

    conv_encoder_top dut (
        .clk      (clk),
        .rst      (rst),
        .dvalid_i (dvalid_i),
        .data_i   (data_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder: c0 = parity(u+s1+s2), c1 = parity(u+s2), MSB first.
    function automatic logic [15:0] model_enc(input logic [7:0] b);
        int w = 0;
        int u;
        for (int i = 7; i >= 0; i--) begin
            u    = (int'(b) >> i) & 1;
            w    = w * 4 + ((u + m_s1 + m_s2) % 2) * 2 + ((u + m_s2) % 2);
            m_s2 = m_s1;
            m_s1 = u;
        end
        return w[15:0];
    endfunction

    // Output monitor: collects transfers and checks stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("stall_stable", {16'h0, data_o}, {16'h0, hold_d});
            if (valid_o && ready_i) got.push_back(data_o);
            hold_v = valid_o && !ready_i;
            hold_d = data_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        dvalid_i = 1'b1;
        data_i   = b;
        tick();
        dvalid_i = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!valid_o && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_words(input int k, input int limit);
        int n = 0;
        while (got.size() < k && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) check("timeout_words", got.size(), k);
    endtask

    task automatic drain(input int c);
        repeat (c) tick();
    endtask

    task automatic do_reset();
        dvalid_i = 1'b0;
        flush_i  = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got.delete();
        m_s1 = 0;
        m_s2 = 0;
    endtask

    initial begin : main
        int n;
        logic [7:0] bytes[17];
        logic [7:0] rq[$];
        int sent;
        int cyc;

        // Reset state.
        repeat (3) tick();
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data", data_o, 0);
        rst = 1'b0;
        tick();

        // Single byte latency and value, one-cycle valid with ready high.
        write_byte(8'h80);
        wait_valid(40, n);
        check("lat_byte", n, 11);
        check("word_80", data_o, 16'hEC00);
        tick();
        check("valid_one_cycle", valid_o, 0);

        // Flush from idle with empty FIFO.
        drain(3);
        pulse_flush();
        wait_valid(40, n);
        check("lat_flush", n, 9);
        check("word_flush0", data_o, 16'h0000);
        drain(5);

        // 0xFF followed by a tail, then 0x00 from the cleared trellis.
        got.delete();
        write_byte(8'hFF);
        pulse_flush();
        wait_words(2, 200);
        drain(40);
        check("ff_flush_cnt", got.size(), 2);
        check("word_ff", got[0], 16'hDAAA);
        check("word_tail_ff", got[1], 16'h7000);
        got.delete();
        write_byte(8'h00);
        wait_words(1, 100);
        check("word_00_after_tail", got[0], 16'h0000);

        // Backpressure: 17 bytes fill FIFO plus FSM; 18th dropped.
        do_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bytes[i] = 8'($urandom);
            write_byte(bytes[i]);
        end
        drain(2);
        check("busy_full", busy_o, 1);
        write_byte(8'hA5);
        drain(20);
        check("stalled_valid", valid_o, 1);
        ready_i = 1'b1;
        wait_words(17, 600);
        drain(40);
        check("bp_count", got.size(), 17);
        for (int i = 0; i < 17; i++) check($sformatf("bp_word%0d", i), got[i], model_enc(bytes[i]));
        check("bp_busy_clear", busy_o, 0);

        // Three flush pulses while stalled and FIFO empty collapse into one tail.
        do_reset();
        ready_i = 1'b0;
        write_byte(8'hFF);
        wait_valid(40, n);
        for (int i = 0; i < 3; i++) begin
            pulse_flush();
            tick();
        end
        ready_i = 1'b1;
        wait_words(2, 200);
        drain(60);
        check("flush3_cnt", got.size(), 2);
        check("flush3_w0", got[0], 16'hDAAA);
        check("flush3_tail", got[1], 16'h7000);

        // Reset in the middle of ENC with two bytes queued.
        do_reset();
        write_byte(8'h80);
        write_byte(8'h11);
        write_byte(8'h22);
        drain(3);
        rst = 1'b1;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_data", data_o, 0);
        tick();
        rst = 1'b0;
        got.delete();
        drain(40);
        check("midrst_no_words", got.size(), 0);
        write_byte(8'h80);
        wait_words(1, 100);
        check("midrst_word_80", got[0], 16'hEC00);
        drain(3);

        // Byte and flush in the same cycle: data first, then tail.
        got.delete();
        dvalid_i = 1'b1;
        data_i   = 8'h80;
        flush_i  = 1'b1;
        tick();
        dvalid_i = 1'b0;
        flush_i  = 1'b0;
        wait_words(2, 200);
        drain(40);
        check("same_cyc_cnt", got.size(), 2);
        check("same_cyc_w0", got[0], 16'hEC00);
        check("same_cyc_tail", got[1], 16'h0000);

        // Random stream with random backpressure, closed by a tail flush.
        do_reset();
        sent = 0;
        cyc  = 0;
        while ((sent < 24 || got.size() < 24) && cyc < 5000) begin
            ready_i  = 1'($urandom_range(0, 1));
            dvalid_i = 1'b0;
            if (sent < 24 && !busy_o && $urandom_range(0, 2) == 0) begin
                dvalid_i = 1'b1;
                data_i   = 8'($urandom);
                rq.push_back(data_i);
                sent++;
            end
            tick();
            cyc++;
        end
        dvalid_i = 1'b0;
        ready_i  = 1'b1;
        check("rand_timeout", (cyc < 5000) ? 1 : 0, 1);
        drain(5);
        pulse_flush();
        wait_words(25, 200);
        drain(30);
        check("rand_cnt", got.size(), 25);
        for (int i = 0; i < 24; i++) check($sformatf("rand_word%0d", i), got[i], model_enc(rq[i]));
        check("rand_tail", got[24], model_enc(8'h00));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
